// File: rtl/inst_encoder.sv
// inst_encoder: packs RV32I fields plus a byte-offset immediate into a 32-bit
// instruction word and flags immediates the chosen format cannot represent.
// Results sit in a 2-entry output FIFO behind valid/ready handshakes. Running
// counts are kept of delivered instructions and of delivered errors.
module inst_encoder #(
  parameter int CPU_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_fmt,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [CPU_WIDTH-1:0] in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CPU_WIDTH-1:0] out_inst,
  output logic                 out_err,
  output logic [CNT_WIDTH-1:0] inst_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;
  localparam logic [2:0] FMT_U = 3'd5;
  localparam logic [CPU_WIDTH-1:0] NOP = 32'h0000_0013;

  // Sign-extension checks: the upper bits must all replicate the top kept bit.
  logic sx11, sx12, sx20;
  assign sx11 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign sx12 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign sx20 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  logic [CPU_WIDTH-1:0] enc_inst;
  logic                 enc_err;

  // Combinational packer. Out-of-range immediates are still packed from their
  // truncated bits so the word is deterministic; only the error flag differs.
  always_comb begin
    enc_inst = NOP;
    enc_err  = 1'b1;
    case (in_fmt)
      FMT_R: begin
        enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_err  = 1'b0;
      end
      FMT_I: begin
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err  = ~sx11;
      end
      FMT_S: begin
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err  = ~sx11;
      end
      FMT_B: begin
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        enc_err  = ~sx12 | in_imm[0];
      end
      FMT_J: begin
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err  = ~sx20 | in_imm[0];
      end
      FMT_U: begin
        enc_inst = {in_imm[31:12], in_rd, in_opcode};
        enc_err  = |in_imm[11:0];
      end
      default: begin
        enc_inst = NOP;
        enc_err  = 1'b1;
      end
    endcase
  end

  // Output FIFO kept as an explicit head/tail pair so the head register drives
  // the outputs directly and simply holds its last value once drained.
  logic [CPU_WIDTH-1:0] head_inst_q, head_inst_d;
  logic [CPU_WIDTH-1:0] tail_inst_q, tail_inst_d;
  logic                 head_err_q, head_err_d;
  logic                 tail_err_q, tail_err_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 rdy_q;
  logic [CNT_WIDTH-1:0] inst_cnt_q, inst_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic push, pop;
  assign push = in_valid & rdy_q;
  assign pop  = (cnt_q != 2'd0) & out_ready;

  // FIFO next-state. A push while full cannot happen because in_ready is
  // registered from the previous occupancy, so it is already low at count=2.
  always_comb begin
    head_inst_d = head_inst_q;
    head_err_d  = head_err_q;
    tail_inst_d = tail_inst_q;
    tail_err_d  = tail_err_q;
    cnt_d       = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_inst_d = enc_inst;
          head_err_d  = enc_err;
          cnt_d       = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_inst_d = enc_inst;
          head_err_d  = enc_err;
        end else if (push) begin
          tail_inst_d = enc_inst;
          tail_err_d  = enc_err;
          cnt_d       = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_inst_d = tail_inst_q;
          head_err_d  = tail_err_q;
          cnt_d       = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  // Delivery statistics: inst_cnt wraps, err_cnt sticks at all-ones.
  always_comb begin
    inst_cnt_d = inst_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (pop) begin
      inst_cnt_d = inst_cnt_q + CNT_WIDTH'(1);
      if (head_err_q && (err_cnt_q != {CNT_WIDTH{1'b1}}))
        err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
    end
  end

  // State registers; reset flushes the FIFO and holds in_ready low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_inst_q <= '0;
      head_err_q  <= 1'b0;
      tail_inst_q <= '0;
      tail_err_q  <= 1'b0;
      cnt_q       <= 2'd0;
      rdy_q       <= 1'b0;
      inst_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      head_inst_q <= head_inst_d;
      head_err_q  <= head_err_d;
      tail_inst_q <= tail_inst_d;
      tail_err_q  <= tail_err_d;
      cnt_q       <= cnt_d;
      rdy_q       <= (cnt_d != 2'd2);
      inst_cnt_q  <= inst_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_inst  = head_inst_q;
  assign out_err   = head_err_q;
  assign inst_cnt  = inst_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: the driver queues the expected word at
// each accepted request; an independent monitor pops and compares on every
// output transfer and checks that stalled outputs stay stable.
module tb_inst_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] inst_cnt, err_cnt;

  inst_encoder #(.CPU_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .inst_cnt(inst_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [32:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference encoder written from signed ranges rather than bit replication.
  function automatic logic [32:0] ref_enc(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    int s;
    logic [31:0] w;
    logic e;
    s = $signed(imm);
    case (f)
      3'd0: begin w = {f7, rs2, rs1, f3, rd, op}; e = 1'b0; end
      3'd1: begin w = {imm[11:0], rs1, f3, rd, op}; e = (s < -2048) || (s > 2047); end
      3'd2: begin w = {imm[11:5], rs2, rs1, f3, imm[4:0], op}; e = (s < -2048) || (s > 2047); end
      3'd3: begin
        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        e = (s < -4096) || (s > 4095) || imm[0];
      end
      3'd4: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        e = (s < -1048576) || (s > 1048575) || imm[0];
      end
      3'd5: begin w = {imm[31:12], rd, op}; e = (imm[11:0] != 12'd0); end
      default: begin w = 32'h0000_0013; e = 1'b1; end
    endcase
    return {e, w};
  endfunction

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm, input logic [32:0] exp);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected accept");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      if (sb.size() == 0) begin @(posedge clk); #1; return; end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
  endtask

  // Monitor: compare on every transfer; check hold while stalled.
  logic        stall_prev = 1'b0;
  logic [32:0] stall_val;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) chk("stall_hold", {31'd0, out_err}, {31'd0, stall_val[32]});
      if (stall_prev) chk("stall_inst", out_inst, stall_val[31:0]);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got %h expected no output", out_inst);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          chk("out_inst", out_inst, e[31:0]);
          chk("out_err", {31'd0, out_err}, {31'd0, e[32]});
        end
      end
      stall_prev <= out_valid && !out_ready;
      stall_val  <= {out_err, out_inst};
    end
  end

  initial begin
    int c0;
    int base;
    // Reset state
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_inst_cnt", {16'd0, inst_cnt}, 32'd0);
    chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Legal encodings of each format
    out_ready = 1'b1;
    send(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, {1'b0, 32'hFFF1_0093});
    chk("latency_1cyc", {31'd0, out_valid}, 32'd1);
    send(3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8, {1'b0, 32'h0051_2423});
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, {1'b0, 32'hFE00_0EE3});
    send(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, {1'b0, 32'h0080_00EF});
    send(3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, {1'b0, 32'h1234_52B7});
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, {1'b0, 32'h4020_81B3});
    drain();
    chk("cnt_legal", {16'd0, inst_cnt}, 32'd6);
    chk("err_legal", {16'd0, err_cnt}, 32'd0);

    // Violations
    send(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048, {1'b1, 32'h8001_0093});
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, {1'b1, 32'h0000_0163});
    send(3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, {1'b1, 32'h1234_52B7});
    send(3'd7, 7'h33, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'd0, {1'b1, 32'h0000_0013});
    drain();
    chk("cnt_err", {16'd0, inst_cnt}, 32'd10);
    chk("err_cnt4", {16'd0, err_cnt}, 32'd4);

    // Backpressure: two fill the buffer, third waits
    out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, {1'b0, 32'h0010_0213});
    send(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, {1'b0, 32'h0020_0213});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      chk("full_head", out_inst, 32'h0010_0213);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_no_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    send(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, {1'b0, 32'h0030_0213});
    drain();
    chk("cnt_bp", {16'd0, inst_cnt}, 32'd13);

    // Streaming 100 random legal requests
    base = 13;
    c0 = cyc;
    for (int k = 0; k < 100; k++) begin
      logic [2:0] f; logic [31:0] imm;
      logic [6:0] op, f7; logic [4:0] rd, r1, r2; logic [2:0] f3;
      f = 3'($urandom_range(0, 5));
      op = 7'($urandom); f7 = 7'($urandom); rd = 5'($urandom);
      r1 = 5'($urandom); r2 = 5'($urandom); f3 = 3'($urandom);
      case (f)
        3'd1, 3'd2: imm = 32'($signed($urandom_range(0, 4095)) - 2048);
        3'd3: imm = 32'($signed($urandom_range(0, 4095)) * 2 - 4096);
        3'd4: imm = 32'($signed($urandom_range(0, 1048575)) * 2 - 1048576);
        3'd5: imm = $urandom & 32'hFFFF_F000;
        default: imm = $urandom;
      endcase
      send(f, op, rd, r1, r2, f3, f7, imm, ref_enc(f, op, rd, r1, r2, f3, f7, imm));
    end
    chk("stream_cycles", 32'(cyc - c0), 32'd100);
    drain();
    chk("cnt_stream", {16'd0, inst_cnt}, 32'(base + 100));

    // Reset mid-operation with two entries buffered
    out_ready = 1'b0;
    send(3'd5, 7'h17, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000, {1'b0, 32'hABCD_E117});
    send(3'd5, 7'h17, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1111_1000, {1'b0, 32'h1111_1197});
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_inst_cnt", {16'd0, inst_cnt}, 32'd0);
    chk("mid_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_cnt", {16'd0, inst_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
